// File: rtl/mem_arbiter2_pkg.sv
// Shared definitions for the mem_arbiter2 block.
//   - state encoding for the arbiter FSM
//   - requester index constants (instruction fetch / load-store)
//   - winner used by the fixed-priority policy on a tie
package arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  // Data accesses win ties so a load/store is never starved by fetch.
  localparam logic FIXED_WINNER = REQ_LS;

  typedef enum logic {
    StIdle = ST_IDLE,
    StBusy = ST_BUSY
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter2_if.sv
// Bundle of the arbiter's requester-side and memory-side signals.
//   slave  : the arbiter's view (consumes requests, drives memory port).
//   master : the environment's view (requesters plus memory).
// Signals: req0_*/req1_* valid/addr/wdata/we in, ready/rdata out;
//          mem_valid/addr/wdata/we out, mem_ready/rdata in; sel, busy out.
interface mem_arbiter2_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_we;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_we;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_rdata;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              sel;
  logic              busy;

  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_we,
    input  req1_valid, req1_addr, req1_wdata, req1_we,
    input  mem_ready, mem_rdata,
    output req0_ready, req0_rdata, req1_ready, req1_rdata,
    output mem_valid, mem_addr, mem_wdata, mem_we,
    output sel, busy
  );

  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_we,
    output req1_valid, req1_addr, req1_wdata, req1_we,
    output mem_ready, mem_rdata,
    input  req0_ready, req0_rdata, req1_ready, req1_rdata,
    input  mem_valid, mem_addr, mem_wdata, mem_we,
    input  sel, busy
  );

endinterface

// File: rtl/mem_arbiter2_pick.sv
// arb_pick: combinational winner selection for mem_arbiter2.
//   valid0/valid1 : pending requests, last_grant : previous tie winner.
//   any : some request pending, tie : both pending, winner : granted index.
// Build option ARB_RR_EN: defined -> round-robin on ties,
// undefined -> fixed priority (load/store wins every tie).
module arb_pick
  import arb_pkg::*;
(
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic any,
  output logic tie,
  output logic winner
);

`ifndef ARB_RR_EN
  // Fixed priority ignores history; keep the input visibly consumed.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    any    = valid0 | valid1;
    tie    = valid0 & valid1;
    winner = REQ_IF;
    if (tie) begin
`ifdef ARB_RR_EN
      winner = ~last_grant;
`else
      winner = FIXED_WINNER;
`endif
    end else if (valid1) begin
      winner = REQ_LS;
    end
  end

endmodule

// File: rtl/mux2x1.sv
// Generic two-input steering multiplexer.
//   in0/in1 : data inputs, sel : select (0 -> in0), y : output.
module Mux2x1 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one memory port between instruction fetch (req0)
// and load/store (req1). One grant at a time, held until mem_ready, with
// one idle cycle between transactions.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter2_if.slave (requesters, memory port, sel, busy)
// Build option ARB_RR_EN selects round-robin tie breaking (see arb_pick).
module mem_arbiter2
  import arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter2_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_grant_q, last_grant_d;
  logic       pick_any, pick_tie, pick_winner;
  logic       busy;
  logic       steered_we;

  arb_pick u_pick (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (last_grant_q),
    .any        (pick_any),
    .tie        (pick_tie),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= REQ_IF;
      last_grant_q <= REQ_LS;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StBusy;
          sel_d   = pick_winner;
          // History only moves on contention.
          if (pick_tie) begin
            last_grant_d = pick_winner;
          end
        end
      end
      StBusy: begin
        // Grant is held even if the requester drops valid early.
        if (bus.mem_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StBusy);

  Mux2x1 #(.W(ADDR_W)) u_addr_mux (
    .in0 (bus.req0_addr),
    .in1 (bus.req1_addr),
    .sel (sel_q),
    .y   (bus.mem_addr)
  );

  Mux2x1 #(.W(DATA_W)) u_wdata_mux (
    .in0 (bus.req0_wdata),
    .in1 (bus.req1_wdata),
    .sel (sel_q),
    .y   (bus.mem_wdata)
  );

  assign steered_we     = (sel_q == REQ_LS) ? bus.req1_we : bus.req0_we;
  assign bus.mem_valid  = busy;
  assign bus.mem_we     = busy & steered_we;
  assign bus.sel        = sel_q;
  assign bus.busy       = busy;

  // mem_ready outside BUSY is ignored; only the granted side sees it.
  assign bus.req0_ready = busy & bus.mem_ready & (sel_q == REQ_IF);
  assign bus.req1_ready = busy & bus.mem_ready & (sel_q == REQ_LS);
  assign bus.req0_rdata = bus.mem_rdata;
  assign bus.req1_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Self-checking bench for mem_arbiter2: directed steps followed by a
// randomized phase checked against a transaction-level reference model.
module tb_mem_arbiter2;
  import arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter2_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  mem_arbiter2 #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Tie policy: round-robin alternates away from the previous tie winner,
  // fixed priority always favours the load/store side.
  function automatic bit tie_winner(input bit last);
    bit w;
    w = !last;
`ifndef ARB_RR_EN
    w = REQ_LS;
`endif
    return w;
  endfunction

  task automatic drive(input int r, input bit v, input logic [31:0] a, input logic [31:0] d,
                       input bit w);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_we = w;
    end else begin
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_we = w;
    end
  endtask

  bit          model_last;
  bit          pend[2];
  logic [31:0] ma[2];
  logic [31:0] md[2];
  bit          mw[2];
  bit          win;
  int          nwait;
  logic [31:0] rd;

  initial begin
    clk = 1'b0;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    drive(0, 1'b0, 32'h0000_AAAA, 32'h5555_0000, 1'b1);
    drive(1, 1'b0, 32'h0000_1111, 32'h2222_0000, 1'b1);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    model_last = REQ_LS;

    // Reset state
    #2;
    check1("rst_mem_valid", bus.mem_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_sel", bus.sel, 1'b0);
    check1("rst_mem_we", bus.mem_we, 1'b0);
    check1("rst_ready0", bus.req0_ready, 1'b0);
    check1("rst_ready1", bus.req1_ready, 1'b0);
    check32("rst_mem_addr", bus.mem_addr, 32'h0000_AAAA);
    check32("rst_mem_wdata", bus.mem_wdata, 32'h5555_0000);
    step();
    rst = 1'b0;

    // mem_ready while idle is ignored
    bus.mem_ready = 1'b1;
    repeat (3) begin
      step();
      check1("idle_ready0", bus.req0_ready, 1'b0);
      check1("idle_ready1", bus.req1_ready, 1'b0);
      check1("idle_busy", bus.busy, 1'b0);
    end

    // req0 read, zero-wait memory
    drive(0, 1'b1, 32'h0000_0010, 32'h0, 1'b0);
    #1;
    check1("rd0_not_yet", bus.mem_valid, 1'b0);
    step();
    check1("rd0_mem_valid", bus.mem_valid, 1'b1);
    check32("rd0_mem_addr", bus.mem_addr, 32'h0000_0010);
    check1("rd0_ready0", bus.req0_ready, 1'b1);
    check1("rd0_ready1", bus.req1_ready, 1'b0);
    check1("rd0_sel", bus.sel, 1'b0);
    check1("rd0_we", bus.mem_we, 1'b0);
    bus.req0_valid = 1'b0;
    step();
    check1("rd0_bubble", bus.mem_valid, 1'b0);
    check1("rd0_ready_once", bus.req0_ready, 1'b0);

    // req1 write with three wait states
    drive(1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 1'b1);
    bus.mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check1("wr1_valid", bus.mem_valid, 1'b1);
      check1("wr1_we", bus.mem_we, 1'b1);
      check32("wr1_addr", bus.mem_addr, 32'h0000_0200);
      check32("wr1_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check1("wr1_sel", bus.sel, 1'b1);
      check1("wr1_wait_ready", bus.req1_ready, 1'b0);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    check1("wr1_ready1", bus.req1_ready, 1'b1);
    check1("wr1_ready0", bus.req0_ready, 1'b0);
    step();
    bus.req1_valid = 1'b0;
    #1;
    check1("wr1_done_busy", bus.busy, 1'b0);
    check1("wr1_done_ready", bus.req1_ready, 1'b0);

    // Read data returned in the ready cycle
    drive(0, 1'b1, 32'h0000_0004, 32'h0, 1'b0);
    bus.mem_rdata = 32'h1234_5678;
    step();
    check1("rdat_ready0", bus.req0_ready, 1'b1);
    check32("rdat_addr", bus.mem_addr, 32'h0000_0004);
    check32("rdat_rdata0", bus.req0_rdata, 32'h1234_5678);
    bus.req0_valid = 1'b0;
    step();

    // Reset mid-BUSY abandons the transaction at once
    bus.mem_ready = 1'b0;
    drive(1, 1'b1, 32'h0000_0300, 32'h0, 1'b0);
    step();
    check1("rstb_busy_pre", bus.busy, 1'b1);
    check1("rstb_sel_pre", bus.sel, 1'b1);
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check1("rstb_mem_valid", bus.mem_valid, 1'b0);
    check1("rstb_busy", bus.busy, 1'b0);
    check1("rstb_sel", bus.sel, 1'b0);
    check1("rstb_ready0", bus.req0_ready, 1'b0);
    check1("rstb_ready1", bus.req1_ready, 1'b0);
    bus.req1_valid = 1'b0;
    step();
    rst = 1'b0;
    model_last = REQ_LS;

    // Both requesters valid continuously
    drive(0, 1'b1, 32'h0000_0100, 32'h0, 1'b0);
    drive(1, 1'b1, 32'h0000_0300, 32'h0, 1'b0);
    bus.mem_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      win = tie_winner(model_last);
      model_last = win;
      check1("tie_sel", bus.sel, win);
      check1("tie_ready0", bus.req0_ready, !win);
      check1("tie_ready1", bus.req1_ready, win);
      check32("tie_addr", bus.mem_addr, win ? 32'h0000_0300 : 32'h0000_0100);
      step();
      check1("tie_bubble", bus.busy, 1'b0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();

    // Randomized traffic against a transaction-level model
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int it = 0; it < 150; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 1) == 1)) begin
          pend[r] = 1'b1;
          ma[r] = $urandom;
          md[r] = $urandom;
          mw[r] = 1'($urandom_range(0, 1));
        end
        drive(r, pend[r], ma[r], md[r], mw[r]);
      end
      bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      check1("rnd_idle_valid", bus.mem_valid, 1'b0);
      check1("rnd_idle_ready0", bus.req0_ready, 1'b0);
      check1("rnd_idle_ready1", bus.req1_ready, 1'b0);
      if (!pend[0] && !pend[1]) begin
        step();
        continue;
      end
      if (pend[0] && pend[1]) begin
        win = tie_winner(model_last);
        model_last = win;
      end else begin
        win = pend[1];
      end
      nwait = $urandom_range(0, 3);
      step();
      for (int i = 0; i <= nwait; i++) begin
        rd = $urandom;
        bus.mem_rdata = rd;
        bus.mem_ready = (i == nwait);
        #1;
        check1("rnd_valid", bus.mem_valid, 1'b1);
        check1("rnd_sel", bus.sel, win);
        check32("rnd_addr", bus.mem_addr, ma[win]);
        check32("rnd_wdata", bus.mem_wdata, md[win]);
        check1("rnd_we", bus.mem_we, mw[win]);
        check1("rnd_ready0", bus.req0_ready, (win == 1'b0) && (i == nwait));
        check1("rnd_ready1", bus.req1_ready, (win == 1'b1) && (i == nwait));
        check32("rnd_rdata", win ? bus.req1_rdata : bus.req0_rdata, rd);
        step();
      end
      pend[win] = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
